fetch_unit: RTL and testbench

Instruction fetch stage of the RV32I core, directly upstream of the decode control unit. Maintains the program counter and issues word requests to instruction memory over a request/grant/response handshake. Buffers returned words, each tagged with its PC, in a small FIFO. Presents them to decode as `instruction_code` with a valid/ready handshake, and flushes on branch/jump redirects from execute.

---
 rtl/fetch_unit.sv | 167 ++++++++++++++++
 tb/tb_fetch_unit.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// RV32I instruction fetch: PC sequencing, single-outstanding imem handshake, tagged instruction FIFO.
// Optional misaligned-redirect trap (HALT state) enabled by defining FETCH_MISALIGN_TRAP_EN.
module fetch_unit #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int unsigned FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        if_valid,
    input  logic        if_ready,
    output logic [31:0] instruction_code,
    output logic [31:0] if_pc,
    output logic        misaligned
);

    localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam logic [31:0] NOP_INSN = 32'h0000_0013;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        ST_REQ,
        ST_WAIT,
`ifdef FETCH_MISALIGN_TRAP_EN
        ST_HALT,
        ST_HDROP,
`endif
        ST_DROP
    } state_e;

    state_e           state_q, state_d;
    logic [31:0]      pc_q, pc_d;
    logic [31:0]      req_pc_q, req_pc_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [PTR_W-1:0] wptr_q, wptr_d;
    logic [PTR_W-1:0] rptr_q, rptr_d;
    logic [31:0]      insn_q [FIFO_DEPTH];
    logic [31:0]      tag_q  [FIFO_DEPTH];

    logic        space_c;
    logic        push_c;
    logic        pop_c;
    logic        resp_open_c;
    logic        trap_c;
    logic [31:0] target_c;

    // Redirect target: either trapped when misaligned or silently word-aligned
`ifdef FETCH_MISALIGN_TRAP_EN
    assign trap_c   = (redirect_pc[1:0] != 2'b00);
    assign target_c = redirect_pc;
`else
    assign trap_c   = 1'b0;
    assign target_c = redirect_pc & 32'hFFFF_FFFC;
`endif

    assign if_valid         = (count_q != '0);
    assign pop_c            = if_valid && if_ready && !redirect;
    assign instruction_code = if_valid ? insn_q[rptr_q] : NOP_INSN;
    assign if_pc            = if_valid ? tag_q[rptr_q] : 32'h0000_0000;
    assign imem_addr        = pc_q;
    assign space_c          = (count_q + CNT_W'(state_q == ST_WAIT)) < DEPTH_C;

    // Fetch FSM next state, request and PC update
    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        req_pc_d    = req_pc_q;
        imem_req    = 1'b0;
        misaligned  = 1'b0;
        push_c      = 1'b0;
        resp_open_c = 1'b0;
        case (state_q)
            ST_REQ: begin
                imem_req    = space_c && !rst;
                resp_open_c = imem_req && imem_gnt;
                if (imem_req && imem_gnt) begin
                    req_pc_d = pc_q;
                    pc_d     = pc_q + 32'd4;
                    state_d  = ST_WAIT;
                end
            end
            ST_WAIT: begin
                resp_open_c = !imem_rvalid;
                if (imem_rvalid) begin
                    push_c  = 1'b1;
                    state_d = ST_REQ;
                end
            end
            ST_DROP: begin
                resp_open_c = !imem_rvalid;
                if (imem_rvalid) state_d = ST_REQ;
            end
`ifdef FETCH_MISALIGN_TRAP_EN
            ST_HALT: begin
                misaligned = 1'b1;
            end
            ST_HDROP: begin
                misaligned  = 1'b1;
                resp_open_c = !imem_rvalid;
                if (imem_rvalid) state_d = ST_HALT;
            end
`endif
            default: state_d = ST_REQ;
        endcase
        if (redirect) begin
            push_c = 1'b0;
            pc_d   = target_c;
`ifdef FETCH_MISALIGN_TRAP_EN
            if (trap_c) state_d = resp_open_c ? ST_HDROP : ST_HALT;
            else        state_d = resp_open_c ? ST_DROP  : ST_REQ;
`else
            state_d = (resp_open_c && !trap_c) ? ST_DROP : ST_REQ;
`endif
        end
    end

    // FIFO occupancy and pointers; redirect flushes
    always_comb begin
        count_d = count_q;
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        if (redirect) begin
            count_d = '0;
            wptr_d  = '0;
            rptr_d  = '0;
        end else begin
            if (push_c) wptr_d = wptr_q + PTR_W'(1);
            if (pop_c)  rptr_d = rptr_q + PTR_W'(1);
            if (push_c && !pop_c)      count_d = count_q + CNT_W'(1);
            else if (!push_c && pop_c) count_d = count_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_REQ;
            pc_q     <= RESET_PC;
            req_pc_q <= 32'h0000_0000;
            count_q  <= '0;
            wptr_q   <= '0;
            rptr_q   <= '0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            req_pc_q <= req_pc_d;
            count_q  <= count_d;
            wptr_q   <= wptr_d;
            rptr_q   <= rptr_d;
        end
    end

    // Payload storage needs no reset; visibility is gated by count_q
    always_ff @(posedge clk) begin
        if (push_c && !rst) begin
            insn_q[wptr_q] <= imem_rdata;
            tag_q[wptr_q]  <= req_pc_q;
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: linear fetch, backpressure, redirects, PC wrap, misaligned redirect, reset mid-request.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        if_ready;

    logic        imem_req;
    logic [31:0] imem_addr;
    logic        if_valid;
    logic [31:0] instruction_code;
    logic [31:0] if_pc;
    logic        misaligned;

    logic        w_req;
    logic [31:0] w_addr;
    logic        w_valid;
    logic [31:0] w_insn;
    logic [31:0] w_pc;
    logic        w_mis;

    int checks = 0;
    int errors = 0;

    localparam logic [31:0] NOP = 32'h0000_0013;
    localparam logic [31:0] W0 = 32'h0010_0093;
    localparam logic [31:0] W1 = 32'h0020_0113;
    localparam logic [31:0] W2 = 32'h0030_0193;
    localparam logic [31:0] W3 = 32'h0040_0213;
    localparam logic [31:0] WS = 32'hDEAD_BEEF;
    localparam logic [31:0] W4 = 32'h0050_0293;
    localparam logic [31:0] W5 = 32'h0060_0313;
    localparam logic [31:0] W6 = 32'h0070_0393;

    always #5 clk = ~clk;

    fetch_unit #(.RESET_PC(32'h0000_0100), .FIFO_DEPTH(2)) u_dut (
        .clk(clk), .rst(rst),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .redirect(redirect), .redirect_pc(redirect_pc),
        .if_valid(if_valid), .if_ready(if_ready),
        .instruction_code(instruction_code), .if_pc(if_pc), .misaligned(misaligned)
    );

    fetch_unit #(.RESET_PC(32'hFFFF_FFFC), .FIFO_DEPTH(2)) u_wrap (
        .clk(clk), .rst(rst),
        .imem_req(w_req), .imem_addr(w_addr), .imem_gnt(imem_gnt),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .redirect(1'b0), .redirect_pc(32'h0000_0000),
        .if_valid(w_valid), .if_ready(if_ready),
        .instruction_code(w_insn), .if_pc(w_pc), .misaligned(w_mis)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        rst = 1'b1; imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0;
        redirect = 1'b0; redirect_pc = '0; if_ready = 1'b0;
        tick(); tick();
        #1;
        chk("rst_req",   32'(imem_req), 32'd0);
        chk("rst_valid", 32'(if_valid), 32'd0);
        chk("rst_insn",  instruction_code, NOP);
        chk("rst_pc",    if_pc, 32'h0);
        chk("rst_mis",   32'(misaligned), 32'd0);
        chk("rst_addr",  imem_addr, 32'h100);
        chk("rst_waddr", w_addr, 32'hFFFF_FFFC);

        // C0: first request right after reset release
        tick(); rst = 1'b0; imem_gnt = 1'b1; #1;
        chk("c0_req",   32'(imem_req), 32'd1);
        chk("c0_addr",  imem_addr, 32'h100);
        chk("c0_wreq",  32'(w_req), 32'd1);
        tick(); imem_gnt = 1'b0; imem_rvalid = 1'b1; imem_rdata = W0; #1;
        chk("c1_req",   32'(imem_req), 32'd0);
        chk("c1_valid", 32'(if_valid), 32'd0);
        tick(); imem_rvalid = 1'b0; imem_gnt = 1'b1; if_ready = 1'b1; #1;
        chk("c2_valid", 32'(if_valid), 32'd1);
        chk("c2_insn",  instruction_code, W0);
        chk("c2_pc",    if_pc, 32'h100);
        chk("c2_addr",  imem_addr, 32'h104);
        chk("wrap_addr", w_addr, 32'h0000_0000);
        chk("wrap_pc",   w_pc, 32'hFFFF_FFFC);
        tick(); imem_gnt = 1'b0; imem_rvalid = 1'b1; imem_rdata = W1; #1;
        chk("c3_valid", 32'(if_valid), 32'd0);
        tick(); imem_rvalid = 1'b0; imem_gnt = 1'b1; #1;
        chk("c4_pc",    if_pc, 32'h104);
        chk("c4_insn",  instruction_code, W1);
        chk("c4_addr",  imem_addr, 32'h108);
        tick(); imem_gnt = 1'b0; imem_rvalid = 1'b1; imem_rdata = W2;
        tick(); imem_rvalid = 1'b0; imem_gnt = 1'b1; if_ready = 1'b0; #1;
        chk("c6_pc",    if_pc, 32'h108);
        chk("c6_insn",  instruction_code, W2);
        chk("c6_addr",  imem_addr, 32'h10C);

        // Backpressure: FIFO fills, request held off until a pop
        tick(); imem_gnt = 1'b0; imem_rvalid = 1'b1; imem_rdata = W3;
        tick(); imem_rvalid = 1'b0; #1;
        chk("full_req", 32'(imem_req), 32'd0);
        chk("full_pc",  if_pc, 32'h108);
        tick(); if_ready = 1'b1; #1;
        chk("pop_req",  32'(imem_req), 32'd0);
        tick(); if_ready = 1'b0; imem_gnt = 1'b1; #1;
        chk("after_pop_req",  32'(imem_req), 32'd1);
        chk("after_pop_addr", imem_addr, 32'h110);
        chk("after_pop_pc",   if_pc, 32'h10C);
        chk("after_pop_insn", instruction_code, W3);

        // Redirect while the 0x110 response is pending
        tick(); imem_gnt = 1'b0; redirect = 1'b1; redirect_pc = 32'h200; #1;
        chk("rd_head",  if_pc, 32'h10C);
        tick(); redirect = 1'b0; imem_rvalid = 1'b1; imem_rdata = WS; #1;
        chk("drop_req",   32'(imem_req), 32'd0);
        chk("drop_valid", 32'(if_valid), 32'd0);
        chk("drop_insn",  instruction_code, NOP);
        chk("drop_pc",    if_pc, 32'h0);
        tick(); imem_rvalid = 1'b0; imem_gnt = 1'b1; #1;
        chk("stale_valid", 32'(if_valid), 32'd0);
        chk("rd_req",      32'(imem_req), 32'd1);
        chk("rd_addr",     imem_addr, 32'h200);
        tick(); imem_gnt = 1'b0; imem_rvalid = 1'b1; imem_rdata = W4;
        tick(); imem_rvalid = 1'b0; imem_gnt = 1'b1; #1;
        chk("rd_pc",    if_pc, 32'h200);
        chk("rd_insn",  instruction_code, W4);
        chk("rd_addr2", imem_addr, 32'h204);

        // Redirect, response and pop in the same cycle
        tick(); imem_gnt = 1'b0; imem_rvalid = 1'b1; imem_rdata = W5;
        redirect = 1'b1; redirect_pc = 32'h300; if_ready = 1'b1; #1;
        chk("sim_pre_valid", 32'(if_valid), 32'd1);
        tick(); imem_rvalid = 1'b0; redirect = 1'b1; redirect_pc = 32'h202; if_ready = 1'b0; #1;
        chk("sim_valid", 32'(if_valid), 32'd0);
        chk("sim_req",   32'(imem_req), 32'd1);
        chk("sim_addr",  imem_addr, 32'h300);
        chk("sim_insn",  instruction_code, NOP);

        // Misaligned redirect to 0x202
        tick(); redirect = 1'b0; #1;
`ifdef FETCH_MISALIGN_TRAP_EN
        chk("mis_req",  32'(imem_req), 32'd0);
        chk("mis_flag", 32'(misaligned), 32'd1);
`else
        chk("mis_req",  32'(imem_req), 32'd1);
        chk("mis_addr", imem_addr, 32'h200);
        chk("mis_flag", 32'(misaligned), 32'd0);
`endif
        tick(); redirect = 1'b1; redirect_pc = 32'h300; #1;
`ifdef FETCH_MISALIGN_TRAP_EN
        chk("mis_req2", 32'(imem_req), 32'd0);
        chk("mis_flag2", 32'(misaligned), 32'd1);
`else
        chk("mis_req2", 32'(imem_req), 32'd1);
        chk("mis_flag2", 32'(misaligned), 32'd0);
`endif
        tick(); redirect = 1'b0; imem_gnt = 1'b1; #1;
        chk("resume_req",  32'(imem_req), 32'd1);
        chk("resume_addr", imem_addr, 32'h300);
        chk("resume_mis",  32'(misaligned), 32'd0);
        tick(); imem_gnt = 1'b0; imem_rvalid = 1'b1; imem_rdata = W6;
        tick(); imem_rvalid = 1'b0; imem_gnt = 1'b1; #1;
        chk("resume_valid", 32'(if_valid), 32'd1);
        chk("resume_pc",    if_pc, 32'h300);
        chk("resume_insn",  instruction_code, W6);

        // Reset while a response is outstanding; late rvalid must be ignored
        tick(); imem_gnt = 1'b0; rst = 1'b1; #1;
        chk("rst2_req", 32'(imem_req), 32'd0);
        tick(); rst = 1'b0; imem_rvalid = 1'b1; imem_rdata = WS; #1;
        chk("rst2_valid", 32'(if_valid), 32'd0);
        chk("rst2_addr",  imem_addr, 32'h100);
        tick(); imem_rvalid = 1'b0; #1;
        chk("rst2_ignored", 32'(if_valid), 32'd0);
        chk("rst2_req2",    32'(imem_req), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
